// File: rtl/tmem_read_responder.sv
// ---------------------------------------------------------------------------
// tmem_read_responder
//
// Responder end of a core's texture-memory (TMEM) read handshake. A core
// raises iTMEMDataRequest with an address. The X component (top WIDTH bits)
// gives a word address on the external TMEM bus. This block reads three
// consecutive words and returns them as one row {word0, word1, word2}. The
// row is held, with oTMEMDataAvailable high, until the core drops its request
// (four-phase handshake).
//
// Optional feature: define TMEM_LAST_TEXEL_CACHE_EN to keep the last
// completed row and its base address. A repeat request to the same base is
// then answered directly from that copy, with no bus traffic. Without the
// macro there is no storage and iCacheInvalidate is ignored.
//
// Ports:
//   Clock              rising-edge system clock
//   Reset              asynchronous active-low reset
//   iTMEMDataRequest   core read request (level)
//   iTMEMReadAddress   request address; only X[MEM_ADDR_W-1:0] is used
//   oTMEMReadData      returned row {word0, word1, word2}
//   oTMEMDataAvailable row valid (level, until the request drops)
//   oMemReadReq        external read request, held until iMemAck
//   oMemAddr           external word address
//   iMemAck            one-cycle acknowledge; iMemData valid with it
//   iMemData           external read data
//   iCacheInvalidate   clears the last-texel cache valid bit
//   oBusy              high whenever the FSM is not idle
//
// MEM_ADDR_W must not exceed WIDTH.
// ---------------------------------------------------------------------------
module tmem_read_responder #(
    parameter int WIDTH      = 32,
    parameter int MEM_ADDR_W = 20
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iTMEMDataRequest,
    input  logic [3*WIDTH-1:0]    iTMEMReadAddress,
    output logic [3*WIDTH-1:0]    oTMEMReadData,
    output logic                  oTMEMDataAvailable,
    output logic                  oMemReadReq,
    output logic [MEM_ADDR_W-1:0] oMemAddr,
    input  logic                  iMemAck,
    input  logic [WIDTH-1:0]      iMemData,
    input  logic                  iCacheInvalidate,
    output logic                  oBusy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_RESPOND = 2'd2,
        S_ABORT   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [1:0]              k_q;
    logic [2*WIDTH-1:0]      partial_q;   // words 0 and 1 while the fetch runs
    logic [3*WIDTH-1:0]      rdata_q;
    logic                    avail_q;
    logic                    mem_req_q;
    logic [MEM_ADDR_W-1:0]   mem_addr_q;

    logic [MEM_ADDR_W-1:0]   req_base;
    assign req_base = iTMEMReadAddress[2*WIDTH +: MEM_ADDR_W];

`ifdef TMEM_LAST_TEXEL_CACHE_EN
    logic [MEM_ADDR_W-1:0]   base_q;
    logic [3*WIDTH-1:0]      cache_row_q;
    logic [MEM_ADDR_W-1:0]   cache_addr_q;
    logic                    cache_valid_q;
    logic                    cache_hit;
    assign cache_hit = cache_valid_q && (cache_addr_q == req_base);

    logic unused_inputs;
    assign unused_inputs = ^iTMEMReadAddress;
`else
    logic unused_inputs;
    assign unused_inputs = ^{iTMEMReadAddress, iCacheInvalidate};
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_IDLE;
            k_q           <= 2'd0;
            partial_q     <= '0;
            rdata_q       <= '0;
            avail_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
`ifdef TMEM_LAST_TEXEL_CACHE_EN
            base_q        <= '0;
            cache_row_q   <= '0;
            cache_addr_q  <= '0;
            cache_valid_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iTMEMDataRequest) begin
`ifdef TMEM_LAST_TEXEL_CACHE_EN
                        base_q <= req_base;
                        if (cache_hit) begin
                            rdata_q <= cache_row_q;
                            avail_q <= 1'b1;
                            state_q <= S_RESPOND;
                        end else
`endif
                        begin
                            k_q        <= 2'd0;
                            mem_addr_q <= req_base;
                            mem_req_q  <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    if (!iTMEMDataRequest) begin
                        // An ack arriving with the drop completes the read in
                        // flight, so nothing is left outstanding.
                        if (iMemAck) begin
                            mem_req_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            state_q   <= S_ABORT;
                        end
                    end else if (iMemAck) begin
                        if (k_q == 2'd2) begin
                            // Last word goes straight into the output row.
                            rdata_q   <= {partial_q, iMemData};
                            avail_q   <= 1'b1;
                            mem_req_q <= 1'b0;
                            state_q   <= S_RESPOND;
`ifdef TMEM_LAST_TEXEL_CACHE_EN
                            cache_row_q   <= {partial_q, iMemData};
                            cache_addr_q  <= base_q;
                            cache_valid_q <= 1'b1;
`endif
                        end else begin
                            if (k_q == 2'd0) begin
                                partial_q[2*WIDTH-1:WIDTH] <= iMemData;
                            end else begin
                                partial_q[WIDTH-1:0] <= iMemData;
                            end
                            k_q        <= k_q + 2'd1;
                            mem_addr_q <= mem_addr_q + MEM_ADDR_W'(1);
                        end
                    end
                end

                S_RESPOND: begin
                    if (!iTMEMDataRequest) begin
                        avail_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                S_ABORT: begin
                    // Let the outstanding read finish; issue nothing further.
                    if (!mem_req_q) begin
                        state_q <= S_IDLE;
                    end else if (iMemAck) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase

`ifdef TMEM_LAST_TEXEL_CACHE_EN
            // Placed after the case so invalidate overrides a same-cycle set.
            if (iCacheInvalidate) begin
                cache_valid_q <= 1'b0;
            end
`endif
        end
    end

    assign oTMEMReadData      = rdata_q;
    assign oTMEMDataAvailable = avail_q;
    assign oMemReadReq        = mem_req_q;
    assign oMemAddr           = mem_addr_q;
    assign oBusy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_tmem_read_responder.sv
module tb_tmem_read_responder;

    logic        Clock;
    logic        Reset;
    logic        iTMEMDataRequest;
    logic [95:0] iTMEMReadAddress;
    logic [95:0] oTMEMReadData;
    logic        oTMEMDataAvailable;
    logic        oMemReadReq;
    logic [19:0] oMemAddr;
    logic        iMemAck;
    logic [31:0] iMemData;
    logic        iCacheInvalidate;
    logic        oBusy;

    int tests_run;
    int tests_failed;

    // memory model state; only the memory process writes the counters
    logic [31:0] mem_words [0:15];
    int          mem_wait;
    logic        spur_ack;
    int          mem_idx;
    int          req_cycles;
    int          addr_unstable;
    int          wait_cnt;
    logic [19:0] held_addr;
    logic [19:0] addr_log [0:255];

    tmem_read_responder #(.WIDTH(32), .MEM_ADDR_W(20)) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .iTMEMDataRequest   (iTMEMDataRequest),
        .iTMEMReadAddress   (iTMEMReadAddress),
        .oTMEMReadData      (oTMEMReadData),
        .oTMEMDataAvailable (oTMEMDataAvailable),
        .oMemReadReq        (oMemReadReq),
        .oMemAddr           (oMemAddr),
        .iMemAck            (iMemAck),
        .iMemData           (iMemData),
        .iCacheInvalidate   (iCacheInvalidate),
        .oBusy              (oBusy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Memory model: decides the ack for the current cycle at the falling edge.
    // Data comes from mem_words indexed by the low address nibble.
    initial begin
        iMemAck       = 1'b0;
        iMemData      = '0;
        mem_idx       = 0;
        req_cycles    = 0;
        addr_unstable = 0;
        wait_cnt      = 0;
        held_addr     = '0;
        forever begin
            @(negedge Clock);
            if (spur_ack) begin
                iMemAck  = 1'b1;
                iMemData = 32'hDEAD_BEEF;
            end else if (oMemReadReq) begin
                req_cycles++;
                if (wait_cnt > 0 && oMemAddr !== held_addr) addr_unstable++;
                held_addr = oMemAddr;
                if (wait_cnt == mem_wait) begin
                    iMemAck  = 1'b1;
                    iMemData = mem_words[oMemAddr[3:0]];
                    if (mem_idx < 256) addr_log[mem_idx] = oMemAddr;
                    mem_idx++;
                    wait_cnt = 0;
                end else begin
                    iMemAck = 1'b0;
                    wait_cnt++;
                end
            end else begin
                iMemAck  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [95:0] mk_addr(input logic [31:0] x);
        return {x, 32'h5555_AAAA, 32'h0F0F_F0F0};
    endfunction

    // Raise a request; return the cycle (0 = cycle in which it is sampled)
    // where oTMEMDataAvailable is first seen high, or -1 on timeout.
    task automatic run_request(input logic [95:0] addr, input int max_cyc, output int avail_cyc);
        avail_cyc = -1;
        @(posedge Clock); #1;
        iTMEMDataRequest = 1'b1;
        iTMEMReadAddress = addr;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge Clock);
            if (oTMEMDataAvailable === 1'b1) begin
                avail_cyc = c;
                break;
            end
        end
        $display("[TB] request X=%h available at cycle %0d data=%h", addr[95:64], avail_cyc, oTMEMReadData);
    endtask

    task automatic drop_request(output logic av_same, output logic av_next, output logic busy_next);
        @(posedge Clock); #1;
        iTMEMDataRequest = 1'b0;
        @(negedge Clock);
        av_same = oTMEMDataAvailable;
        @(negedge Clock);
        av_next   = oTMEMDataAvailable;
        busy_next = oBusy;
    endtask

    task automatic test_reset();
        Reset            = 1'b0;
        iTMEMDataRequest = 1'b0;
        iTMEMReadAddress = '0;
        iCacheInvalidate = 1'b0;
        spur_ack         = 1'b0;
        mem_wait         = 0;
        for (int i = 0; i < 16; i++) mem_words[i] = '0;
        repeat (3) @(negedge Clock);
        tests_run++;
        if ({oTMEMReadData, oTMEMDataAvailable, oMemReadReq, oMemAddr, oBusy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: data=%h avail=%b req=%b addr=%h busy=%b, all 0 required",
                     oTMEMReadData, oTMEMDataAvailable, oMemReadReq, oMemAddr, oBusy);
        end
        Reset = 1'b1;
        @(negedge Clock);
        tests_run++;
        if (oBusy !== 1'b0 || oMemReadReq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: busy=%b req=%b, 0 required", oBusy, oMemReadReq);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        int av, s_idx, s_req;
        logic a0, a1, b1;
        logic [95:0] exp;
        mem_wait = 0;
        mem_words[0] = 32'hA; mem_words[1] = 32'hB; mem_words[2] = 32'hC;
        exp   = {32'hA, 32'hB, 32'hC};
        s_idx = mem_idx;
        s_req = req_cycles;
        run_request(mk_addr(32'h0000_0100), 40, av);
        tests_run++;
        if (av !== 4) begin tests_failed++; $display("FAIL basic_latency: cycle %0d, 4 required", av); end
        tests_run++;
        if ((req_cycles - s_req) !== 3) begin
            tests_failed++; $display("FAIL basic_req_cycles: %0d, 3 required", req_cycles - s_req);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (addr_log[s_idx + i] !== 20'(32'h100 + i)) begin
                tests_failed++;
                $display("FAIL basic_addr%0d: %h, %h required", i, addr_log[s_idx + i], 20'(32'h100 + i));
            end
        end
        tests_run++;
        if (oTMEMReadData !== exp) begin
            tests_failed++; $display("FAIL basic_data: %h, %h required", oTMEMReadData, exp);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            tests_run++;
            if (oTMEMDataAvailable !== 1'b1 || oTMEMReadData !== exp || oMemReadReq !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_hold: avail=%b data=%h req=%b, 1/%h/0 required",
                         oTMEMDataAvailable, oTMEMReadData, oMemReadReq, exp);
            end
        end
        drop_request(a0, a1, b1);
        tests_run++;
        if (a0 !== 1'b1 || a1 !== 1'b0 || b1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_drop: avail same=%b next=%b busy=%b, 1/0/0 required", a0, a1, b1);
        end
    endtask

    task automatic test_wait_states();
        int av, s_idx, s_req, s_uns;
        logic a0, a1, b1;
        mem_wait = 3;
        mem_words[5] = 32'h1111_0001; mem_words[6] = 32'h2222_0002; mem_words[7] = 32'h3333_0003;
        s_idx = mem_idx; s_req = req_cycles; s_uns = addr_unstable;
        run_request(mk_addr(32'h0000_0345), 60, av);
        tests_run++;
        if (av !== 13) begin tests_failed++; $display("FAIL wait_latency: cycle %0d, 13 required", av); end
        tests_run++;
        if ((req_cycles - s_req) !== 12 || (addr_unstable - s_uns) !== 0) begin
            tests_failed++;
            $display("FAIL wait_req_stable: req cycles %0d, addr changes %0d; 12 and 0 required",
                     req_cycles - s_req, addr_unstable - s_uns);
        end
        tests_run++;
        if (addr_log[s_idx + 2] !== 20'h00347) begin
            tests_failed++; $display("FAIL wait_addr2: %h, 00347 required", addr_log[s_idx + 2]);
        end
        tests_run++;
        if (oTMEMReadData !== {32'h1111_0001, 32'h2222_0002, 32'h3333_0003}) begin
            tests_failed++; $display("FAIL wait_data: %h", oTMEMReadData);
        end
        drop_request(a0, a1, b1);
        mem_wait = 0;
    endtask

    task automatic test_wrap();
        int av, s_idx;
        logic a0, a1, b1;
        mem_words[15] = 32'hF0F0_000F; mem_words[0] = 32'h0A0A_0000; mem_words[1] = 32'h1B1B_0001;
        s_idx = mem_idx;
        run_request(mk_addr(32'hABCF_FFFF), 40, av);
        tests_run++;
        if (addr_log[s_idx] !== 20'hFFFFF || addr_log[s_idx + 1] !== 20'h00000 || addr_log[s_idx + 2] !== 20'h00001) begin
            tests_failed++;
            $display("FAIL wrap_addr: %h %h %h, FFFFF 00000 00001 required",
                     addr_log[s_idx], addr_log[s_idx + 1], addr_log[s_idx + 2]);
        end
        tests_run++;
        if (oTMEMReadData !== {32'hF0F0_000F, 32'h0A0A_0000, 32'h1B1B_0001} || av !== 4) begin
            tests_failed++; $display("FAIL wrap_data: %h at cycle %0d", oTMEMReadData, av);
        end
        drop_request(a0, a1, b1);
    endtask

    task automatic test_back_to_back();
        int av, s_req;
        mem_words[0] = 32'h5000_0000; mem_words[1] = 32'h5000_0001; mem_words[2] = 32'h5000_0002;
        s_req = req_cycles;
        run_request(mk_addr(32'h0000_0500), 40, av);
        // request held in RESPOND: no re-serve, no bus activity
        repeat (4) @(negedge Clock);
        tests_run++;
        if ((req_cycles - s_req) !== 3 || oTMEMDataAvailable !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_hold: req cycles %0d avail %b, 3 and 1 required", req_cycles - s_req, oTMEMDataAvailable);
        end
        // drop for exactly one cycle, then request a new row
        @(posedge Clock); #1;
        iTMEMDataRequest = 1'b0;
        mem_words[0] = 32'h6000_0000; mem_words[1] = 32'h6000_0001; mem_words[2] = 32'h6000_0002;
        @(posedge Clock); #1;
        iTMEMDataRequest = 1'b1;
        iTMEMReadAddress = mk_addr(32'h0000_0600);
        av = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clock);
            if (c == 0 && oTMEMDataAvailable !== 1'b0) begin
                tests_run++; tests_failed++;
                $display("FAIL b2b_gap: avail %b during drop, 0 required", oTMEMDataAvailable);
            end
            if (oTMEMDataAvailable === 1'b1 && c > 0) begin av = c; break; end
        end
        $display("[TB] back-to-back X=00000600 available at cycle %0d data=%h", av, oTMEMReadData);
        tests_run++;
        if (av !== 4 || oTMEMReadData !== {32'h6000_0000, 32'h6000_0001, 32'h6000_0002}) begin
            tests_failed++; $display("FAIL b2b_second: cycle %0d data %h, 4 and 600000006000000160000002 required", av, oTMEMReadData);
        end
        @(posedge Clock); #1;
        iTMEMDataRequest = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    task automatic test_abort();
        int s_idx;
        logic saw_av;
        mem_wait = 2;
        s_idx = mem_idx;
        @(posedge Clock); #1;
        iTMEMDataRequest = 1'b1;
        iTMEMReadAddress = mk_addr(32'h0000_0610);
        repeat (4) @(negedge Clock);   // word 0 acked in cycle 3
        @(posedge Clock); #1;
        iTMEMDataRequest = 1'b0;       // second read now outstanding
        saw_av = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clock);
            if (oTMEMDataAvailable !== 1'b0) saw_av = 1'b1;
        end
        $display("[TB] abort X=00000610 acks=%0d busy=%b", mem_idx - s_idx, oBusy);
        tests_run++;
        if ((mem_idx - s_idx) !== 2 || addr_log[s_idx + 1] !== 20'h00611) begin
            tests_failed++;
            $display("FAIL abort_reads: %0d reads, last %h; 2 reads ending at 00611 required",
                     mem_idx - s_idx, addr_log[s_idx + 1]);
        end
        tests_run++;
        if (saw_av !== 1'b0 || oBusy !== 1'b0 || oMemReadReq !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state: avail seen %b busy %b req %b, all 0 required", saw_av, oBusy, oMemReadReq);
        end
        tests_run++;
        if (oTMEMReadData !== {32'h6000_0000, 32'h6000_0001, 32'h6000_0002}) begin
            tests_failed++; $display("FAIL abort_data_kept: %h", oTMEMReadData);
        end
        mem_wait = 0;
    endtask

    task automatic test_spurious_ack();
        logic bad;
        bad = 1'b0;
        spur_ack = 1'b1;
        repeat (3) begin
            @(posedge Clock); #1;
            if (oMemReadReq !== 1'b0 || oBusy !== 1'b0) bad = 1'b1;
        end
        spur_ack = 1'b0;
        repeat (2) @(negedge Clock);
        tests_run++;
        if (bad !== 1'b0 || oTMEMReadData !== {32'h6000_0000, 32'h6000_0001, 32'h6000_0002}) begin
            tests_failed++; $display("FAIL spurious_ack: reacted %b data %h", bad, oTMEMReadData);
        end
        $display("[TB] spurious ack in idle ignored=%b", ~bad);
    endtask

    task automatic test_reset_mid_fetch();
        int av, s_idx;
        logic a0, a1, b1;
        mem_wait = 1;
        @(posedge Clock); #1;
        iTMEMDataRequest = 1'b1;
        iTMEMReadAddress = mk_addr(32'h0000_0700);
        repeat (4) @(negedge Clock);   // second word outstanding
        #2 Reset = 1'b0;
        #1;
        tests_run++;
        if ({oTMEMReadData, oTMEMDataAvailable, oMemReadReq, oMemAddr, oBusy} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: data=%h avail=%b req=%b addr=%h busy=%b, all 0 required",
                     oTMEMReadData, oTMEMDataAvailable, oMemReadReq, oMemAddr, oBusy);
        end
        iTMEMDataRequest = 1'b0;
        mem_wait = 0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        mem_words[0] = 32'h8000_0000; mem_words[1] = 32'h8000_0001; mem_words[2] = 32'h8000_0002;
        s_idx = mem_idx;
        run_request(mk_addr(32'h0000_0800), 40, av);
        tests_run++;
        if (av !== 4 || addr_log[s_idx] !== 20'h00800 || addr_log[s_idx + 2] !== 20'h00802) begin
            tests_failed++;
            $display("FAIL midreset_refetch: cycle %0d addrs %h..%h, 4 and 00800..00802 required",
                     av, addr_log[s_idx], addr_log[s_idx + 2]);
        end
        tests_run++;
        if (oTMEMReadData !== {32'h8000_0000, 32'h8000_0001, 32'h8000_0002}) begin
            tests_failed++; $display("FAIL midreset_data: %h", oTMEMReadData);
        end
        drop_request(a0, a1, b1);
    endtask

    task automatic test_cache();
        int av, s_req;
        logic a0, a1, b1;
        logic [95:0] exp;
        mem_words[0] = 32'h9000_0000; mem_words[1] = 32'h9000_0001; mem_words[2] = 32'h9000_0002;
        exp = {32'h9000_0000, 32'h9000_0001, 32'h9000_0002};
        run_request(mk_addr(32'h0000_0900), 40, av);
        drop_request(a0, a1, b1);
        mem_words[0] = 32'h0; mem_words[1] = 32'h0; mem_words[2] = 32'h0;  // a bus read would show
        s_req = req_cycles;
        run_request(mk_addr(32'h0000_0900), 40, av);
`ifdef TMEM_LAST_TEXEL_CACHE_EN
        tests_run++;
        if (av !== 1 || (req_cycles - s_req) !== 0 || oTMEMReadData !== exp) begin
            tests_failed++;
            $display("FAIL cache_hit: cycle %0d req cycles %0d data %h; 1, 0, %h required",
                     av, req_cycles - s_req, oTMEMReadData, exp);
        end
        drop_request(a0, a1, b1);
        @(posedge Clock); #1;
        iCacheInvalidate = 1'b1;
        @(posedge Clock); #1;
        iCacheInvalidate = 1'b0;
        s_req = req_cycles;
        run_request(mk_addr(32'h0000_0900), 40, av);
        tests_run++;
        if (av !== 4 || (req_cycles - s_req) !== 3 || oTMEMReadData !== '0) begin
            tests_failed++;
            $display("FAIL cache_invalidate: cycle %0d req cycles %0d data %h; 4, 3, 0 required",
                     av, req_cycles - s_req, oTMEMReadData);
        end
`else
        tests_run++;
        if (av !== 4 || (req_cycles - s_req) !== 3 || oTMEMReadData !== '0 || exp === '0) begin
            tests_failed++;
            $display("FAIL nocache_refetch: cycle %0d req cycles %0d data %h; 4, 3, 0 required",
                     av, req_cycles - s_req, oTMEMReadData);
        end
`endif
        drop_request(a0, a1, b1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_wait_states();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_spurious_ack();
        test_reset_mid_fetch();
        test_cache();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
